usb_ep0_ctrl: RTL and testbench

- Endpoint-0 control-transfer sequencer for the hub.
- Consumes decoded packets from the downstream SIE (end-of-packet strobe, PID, address, endpoint, 64-bit payload) and tracks SETUP / STATUS stages.
- Issues handshake and data-packet requests to the upstream transmitter.
- Owns the hub's device address and configuration value: commits SET_ADDRESS only after a successful status stage.

---
 rtl/usb_ep0_ctrl_pkg.sv | 29 ++
 rtl/usb_setup_decode.sv | 25 ++
 rtl/usb_ep0_ctrl.sv | 154 +++++++++++++++
 tb/tb_usb_ep0_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep0_ctrl_pkg.sv
// Shared USB endpoint-0 types: PID encodings, standard request codes, setup layout, sequencer states.
package usb_ep0_ctrl_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  localparam logic [7:0] REQ_SET_ADDRESS = 8'h05;
  localparam logic [7:0] REQ_SET_CONFIG  = 8'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP_DATA,
    ST_ACK_SETUP,
    ST_STATUS_WAIT,
    ST_STATUS_TX,
    ST_STATUS_HS,
    ST_COMMIT,
    ST_RESP
  } ep0_state_t;

endpackage

// File: rtl/usb_setup_decode.sv
// Combinational split of an 8-byte setup packet (byte0 in [7:0]) into its standard fields.
// Flags the two requests the hub endpoint services itself: standard device SET_ADDRESS / SET_CONFIGURATION.
module usb_setup_decode
  import usb_ep0_ctrl_pkg::*;
(
  input  logic [63:0] setup,
  output logic [7:0]  bm_request_type,
  output logic [7:0]  b_request,
  output logic [15:0] w_value,
  output logic [15:0] w_length,
  output logic        supported
);

  logic unused_w_index;

  assign bm_request_type = setup[7:0];
  assign b_request       = setup[15:8];
  assign w_value         = setup[31:16];
  assign w_length        = setup[63:48];
  assign unused_w_index  = ^setup[47:32];

  assign supported = (bm_request_type == 8'h00) &&
                     ((b_request == REQ_SET_ADDRESS) || (b_request == REQ_SET_CONFIG));

endmodule

// File: rtl/usb_ep0_ctrl.sv
// Endpoint-0 control-transfer sequencer: SETUP/DATA0 capture, status stage, address/config commit.
// Responses are registered (one cycle after the packet strobe); tx_req holds until tx_ack or timeout.
module usb_ep0_ctrl
  import usb_ep0_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16'd1200,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_reset,
  input  logic        pkt_valid,
  input  logic        pkt_error,
  input  logic [3:0]  pid_in,
  input  logic [6:0]  addr_in,
  input  logic [3:0]  endp_in,
  input  logic [63:0] data_in,
  output logic        tx_req,
  output logic [3:0]  tx_pid,
  output logic        tx_zlp,
  input  logic        tx_ack,
  output logic [6:0]  dev_addr,
  output logic        addr_loaded,
  output logic [7:0]  config_value,
  output logic        stalled
);

  ep0_state_t      state, ns, ret_state;
  logic [TO_W-1:0] to_cnt;
  logic [63:0]     setup_data;
  logic [7:0]      bm_request_type, b_request;
  logic [15:0]     w_value, w_length;
  logic            supported, unused_dec;
  logic            good, is_tok, tok_hit, setup_tok, in_tok, out_tok, other;
  logic            counting, timeout, restart;

  usb_setup_decode u_decode (
    .setup           (setup_data),
    .bm_request_type (bm_request_type),
    .b_request       (b_request),
    .w_value         (w_value),
    .w_length        (w_length),
    .supported       (supported)
  );

  assign unused_dec = ^{w_length, w_value[15:8], bm_request_type};

  assign good      = pkt_valid && !pkt_error;
  assign is_tok    = (pid_in == PID_SETUP) || (pid_in == PID_IN) || (pid_in == PID_OUT);
  assign tok_hit   = good && is_tok && (addr_in == dev_addr) && (endp_in == 4'd0);
  assign setup_tok = tok_hit && (pid_in == PID_SETUP);
  assign in_tok    = tok_hit && (pid_in == PID_IN);
  assign out_tok   = tok_hit && (pid_in == PID_OUT);
  // Tokens for another device/endpoint are invisible, never an "other packet".
  assign other     = good && (!is_tok || tok_hit);
  assign counting  = (state != ST_IDLE) && (state != ST_COMMIT);
  assign timeout   = counting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign restart   = (state == ST_SETUP_DATA) && setup_tok;

  always_comb begin
    ns = state;
    case (state)
      ST_IDLE:
        if (setup_tok)              ns = ST_SETUP_DATA;
        else if (in_tok || out_tok) ns = ST_RESP;
      ST_SETUP_DATA:
        if (setup_tok)                           ns = ST_SETUP_DATA;
        else if (good && pid_in == PID_DATA0)    ns = ST_ACK_SETUP;
        else if (other || timeout)               ns = ST_IDLE;
      ST_ACK_SETUP:
        if (tx_ack)       ns = supported ? ST_STATUS_WAIT : ST_IDLE;
        else if (timeout) ns = ST_IDLE;
      ST_STATUS_WAIT:
        if (setup_tok)    ns = ST_SETUP_DATA;
        else if (in_tok)  ns = ST_STATUS_TX;
        else if (out_tok) ns = ST_RESP;
        else if (timeout) ns = ST_IDLE;
      ST_STATUS_TX:
        if (tx_ack)       ns = ST_STATUS_HS;
        else if (timeout) ns = ST_IDLE;
      ST_STATUS_HS:
        if (setup_tok)                      ns = ST_SETUP_DATA;
        else if (in_tok)                    ns = ST_STATUS_TX;
        else if (good && pid_in == PID_ACK) ns = ST_COMMIT;
        else if (other || timeout)          ns = ST_IDLE;
      ST_COMMIT:
        ns = setup_tok ? ST_SETUP_DATA : ST_IDLE;
      ST_RESP:
        if (tx_ack)       ns = ret_state;
        else if (timeout) ns = ST_IDLE;
      default: ns = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ret_state    <= ST_IDLE;
      to_cnt       <= '0;
      setup_data   <= '0;
      tx_req       <= 1'b0;
      tx_pid       <= PID_ACK;
      tx_zlp       <= 1'b0;
      dev_addr     <= '0;
      addr_loaded  <= 1'b0;
      config_value <= '0;
      stalled      <= 1'b0;
    end else if (bus_reset) begin
      state        <= ST_IDLE;
      ret_state    <= ST_IDLE;
      to_cnt       <= '0;
      setup_data   <= '0;
      tx_req       <= 1'b0;
      tx_pid       <= PID_ACK;
      tx_zlp       <= 1'b0;
      dev_addr     <= '0;
      addr_loaded  <= 1'b0;
      config_value <= '0;
      stalled      <= 1'b0;
    end else begin
      state       <= ns;
      to_cnt      <= (ns != state || restart || !counting) ? '0 : to_cnt + 1'b1;
      addr_loaded <= 1'b0;
      tx_req      <= (ns == ST_ACK_SETUP) || (ns == ST_STATUS_TX) || (ns == ST_RESP);
      tx_zlp      <= (ns == ST_STATUS_TX);
      if (ns != state) begin
        case (ns)
          ST_ACK_SETUP: tx_pid <= PID_ACK;
          ST_STATUS_TX: tx_pid <= PID_DATA1;
          ST_RESP: begin
            tx_pid    <= (state == ST_IDLE && stalled) ? PID_STALL : PID_NAK;
            ret_state <= state;
          end
          default: ;
        endcase
      end
      if (state == ST_SETUP_DATA && ns == ST_ACK_SETUP) begin
        setup_data <= data_in;
        stalled    <= 1'b0;
      end
      if (state == ST_ACK_SETUP && tx_ack && !supported) stalled <= 1'b1;
      // Commit on entry to COMMIT so the old address served the status IN.
      if (state == ST_STATUS_HS && ns == ST_COMMIT) begin
        if (b_request == REQ_SET_ADDRESS) begin
          dev_addr    <= w_value[6:0];
          addr_loaded <= 1'b1;
        end else if (b_request == REQ_SET_CONFIG) begin
          config_value <= w_value[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_ep0_ctrl.sv
// Directed bench for usb_ep0_ctrl: control transfers, filtering, timeouts, bus and async reset.
module tb_usb_ep0_ctrl;
  import usb_ep0_ctrl_pkg::*;

  localparam int T = 1200;

  logic        clk = 1'b0;
  logic        rst_n, bus_reset, pkt_valid, pkt_error, tx_ack;
  logic [3:0]  pid_in, endp_in;
  logic [6:0]  addr_in;
  logic [63:0] data_in;
  logic        tx_req, tx_zlp, addr_loaded, stalled;
  logic [3:0]  tx_pid;
  logic [6:0]  dev_addr;
  logic [7:0]  config_value;

  int n_chk  = 0;
  int n_pass = 0;
  int n_load = 0;

  usb_ep0_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_reset    (bus_reset),
    .pkt_valid    (pkt_valid),
    .pkt_error    (pkt_error),
    .pid_in       (pid_in),
    .addr_in      (addr_in),
    .endp_in      (endp_in),
    .data_in      (data_in),
    .tx_req       (tx_req),
    .tx_pid       (tx_pid),
    .tx_zlp       (tx_zlp),
    .tx_ack       (tx_ack),
    .dev_addr     (dev_addr),
    .addr_loaded  (addr_loaded),
    .config_value (config_value),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (addr_loaded) n_load++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] req(input logic [7:0] bm, input logic [7:0] br,
                                      input logic [15:0] wv);
    return {16'h0000, 16'h0000, wv, br, bm};
  endfunction

  // Called at a negedge; the packet is sampled on the next posedge.
  task automatic send(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e,
                      input logic [63:0] d, input logic err);
    pid_in = pid; addr_in = a; endp_in = e; data_in = d; pkt_error = err; pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0; pkt_error = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input logic [3:0] pid, input logic zlp);
    int w;
    w = 0;
    while (!tx_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_req"}, tx_req, 1);
    check({tag, "_pid"}, tx_pid, pid);
    check({tag, "_zlp"}, tx_zlp, zlp);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      if (tx_req) seen = 1'b1;
      @(negedge clk);
    end
    check(tag, seen, 0);
  endtask

  task automatic setup_stage(input string tag, input logic [6:0] a, input logic [63:0] d);
    send(PID_SETUP, a, 4'd0, 64'd0, 1'b0);
    send(PID_DATA0, 7'd0, 4'd0, d, 1'b0);
    expect_tx(tag, PID_ACK, 1'b0);
  endtask

  task automatic status_stage(input string tag, input logic [6:0] a);
    send(PID_IN, a, 4'd0, 64'd0, 1'b0);
    expect_tx(tag, PID_DATA1, 1'b1);
    send(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; bus_reset = 1'b0; pkt_valid = 1'b0; pkt_error = 1'b0; tx_ack = 1'b0;
    pid_in = 4'd0; addr_in = 7'd0; endp_in = 4'd0; data_in = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_pid", tx_pid, PID_ACK);
    check("rst_tx_zlp", tx_zlp, 0);
    check("rst_dev_addr", dev_addr, 0);
    check("rst_config", config_value, 0);
    check("rst_stalled", stalled, 0);
    check("rst_addr_loaded", addr_loaded, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Filtering: wrong address, wrong endpoint, corrupted token; then a real IN gets NAK
    send(PID_IN, 7'd5, 4'd0, 64'd0, 1'b0);  expect_quiet("filt_addr", 8);
    send(PID_IN, 7'd0, 4'd1, 64'd0, 1'b0);  expect_quiet("filt_endp", 8);
    send(PID_IN, 7'd0, 4'd0, 64'd0, 1'b1);  expect_quiet("filt_err_tok", 8);
    send(PID_IN, 7'd0, 4'd0, 64'd0, 1'b0);  expect_tx("idle_in", PID_NAK, 1'b0);

    // SET_ADDRESS whose status handshake never arrives
    setup_stage("to_setup", 7'd0, req(8'h00, 8'h05, 16'h002A));
    send(PID_IN, 7'd0, 4'd0, 64'd0, 1'b0);
    expect_tx("to_data1", PID_DATA1, 1'b1);
    repeat (T + 5) @(negedge clk);
    check("to_hs_req", tx_req, 0);
    send(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    @(negedge clk);
    check("to_hs_addr", dev_addr, 0);
    send(PID_IN, 7'd0, 4'd0, 64'd0, 1'b0);
    expect_tx("to_hs_idle", PID_NAK, 1'b0);

    // SET_ADDRESS(0x2A) with an OUT NAKed during status wait
    setup_stage("sa_setup", 7'd0, req(8'h00, 8'h05, 16'h002A));
    send(PID_OUT, 7'd0, 4'd0, 64'd0, 1'b0);
    expect_tx("sa_out", PID_NAK, 1'b0);
    send(PID_IN, 7'd0, 4'd0, 64'd0, 1'b0);
    expect_tx("sa_status", PID_DATA1, 1'b1);
    check("sa_pre_load", addr_loaded, 0);
    send(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    check("sa_load_pulse", addr_loaded, 1);
    check("sa_addr", dev_addr, 7'h2A);
    @(negedge clk);
    check("sa_load_drop", addr_loaded, 0);
    send(PID_IN, 7'd0, 4'd0, 64'd0, 1'b0);  expect_quiet("sa_old_addr", 8);

    // SET_CONFIGURATION(3)
    setup_stage("cfg_setup", 7'h2A, req(8'h00, 8'h09, 16'h0003));
    status_stage("cfg_status", 7'h2A);
    check("cfg_value", config_value, 8'h03);
    check("cfg_addr", dev_addr, 7'h2A);

    // Unsupported GET_DESCRIPTOR: ACKed, then stall until the next SETUP
    setup_stage("uns_setup", 7'h2A, req(8'h80, 8'h06, 16'h0100));
    check("uns_stalled", stalled, 1);
    send(PID_IN, 7'h2A, 4'd0, 64'd0, 1'b0);
    expect_tx("uns_in", PID_STALL, 1'b0);
    send(PID_SETUP, 7'h2A, 4'd0, 64'd0, 1'b0);
    send(PID_DATA0, 7'd0, 4'd0, req(8'h00, 8'h09, 16'h0005), 1'b0);
    check("uns_cleared", stalled, 0);
    expect_tx("uns_new_ack", PID_ACK, 1'b0);
    status_stage("uns_new_status", 7'h2A);
    check("uns_new_cfg", config_value, 8'h05);

    // Corrupted DATA0 is ignored; SETUP_DATA still accepts a clean one
    send(PID_SETUP, 7'h2A, 4'd0, 64'd0, 1'b0);
    send(PID_DATA0, 7'd0, 4'd0, req(8'h00, 8'h05, 16'h0010), 1'b1);
    expect_quiet("err_data0", 6);
    send(PID_DATA0, 7'd0, 4'd0, req(8'h00, 8'h05, 16'h0010), 1'b0);
    expect_tx("err_retry", PID_ACK, 1'b0);
    status_stage("err_status", 7'h2A);
    check("err_addr", dev_addr, 7'h10);

    // SETUP_DATA timeout: late-but-in-time DATA0 is ACKed; aborted transfer commits nothing
    send(PID_SETUP, 7'h10, 4'd0, 64'd0, 1'b0);
    repeat (T - 4) @(negedge clk);
    send(PID_DATA0, 7'd0, 4'd0, req(8'h00, 8'h09, 16'h0007), 1'b0);
    expect_tx("sd_in_time", PID_ACK, 1'b0);
    send(PID_SETUP, 7'h10, 4'd0, 64'd0, 1'b0);
    repeat (T + 2) @(negedge clk);
    send(PID_DATA0, 7'd0, 4'd0, req(8'h00, 8'h09, 16'h0007), 1'b0);
    expect_quiet("sd_timeout", 8);
    check("sd_cfg_kept", config_value, 8'h05);

    // bus_reset wins over a simultaneous status ACK
    setup_stage("br_setup", 7'h10, req(8'h00, 8'h05, 16'h0033));
    send(PID_IN, 7'h10, 4'd0, 64'd0, 1'b0);
    expect_tx("br_data1", PID_DATA1, 1'b1);
    bus_reset = 1'b1;
    send(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    bus_reset = 1'b0;
    check("br_addr", dev_addr, 0);
    check("br_load", addr_loaded, 0);
    check("br_cfg", config_value, 0);
    @(negedge clk);
    check("br_load_late", addr_loaded, 0);
    send(PID_IN, 7'd0, 4'd0, 64'd0, 1'b0);
    expect_tx("br_idle", PID_NAK, 1'b0);

    // Async reset drops tx_req without a clock edge
    send(PID_SETUP, 7'd0, 4'd0, 64'd0, 1'b0);
    send(PID_DATA0, 7'd0, 4'd0, req(8'h00, 8'h05, 16'h0001), 1'b0);
    check("ar_req_high", tx_req, 1);
    #2 rst_n = 1'b0;
    #1 check("ar_req_async", tx_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("load_count", n_load, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
